// File: rtl/feistel_round_engine.sv
// -----------------------------------------------------------------------------
// feistel_round_engine
//
// Iterative Feistel block cipher. One round is computed per clock; each block
// is encrypted or decrypted according to the mode sampled when it is accepted.
// The engine sits between the key/text shift registers and the display mux and
// uses valid/ready handshakes on both sides so a front-end can stream blocks.
//
// Optional build macro: FEISTEL_CHAIN_EN
//   Defined   -> CBC-style chaining through an internal chain register.
//   Undefined -> each block is processed independently (ECB).
//
// Parameters:
//   BLOCK_W     block width, even and >= 8 (half width H = BLOCK_W/2)
//   NUM_ROUNDS  Feistel rounds per block, >= 1
//   ROUND_CONST round-constant multiplier (low H bits of each product used)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any block in flight
//   mode       in   0 = encrypt, 1 = decrypt (sampled on input handshake)
//   key        in   cipher key (sampled on input handshake)
//   in_data    in   input block {L,R}, L in the upper half
//   in_valid   in   input block offered
//   in_ready   out  engine idle and able to accept a block
//   out_data   out  result block {L,R}, held until the output handshake
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   busy       out  rounds executing
// -----------------------------------------------------------------------------
module feistel_round_engine #(
    parameter int          BLOCK_W     = 16,
    parameter int          NUM_ROUNDS  = 8,
    parameter logic [31:0] ROUND_CONST = 32'h9E3779B9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int H  = BLOCK_W / 2;
    localparam int CW = $clog2(NUM_ROUNDS) + 1;
    // Wide enough that (r+1)*ROUND_CONST never overflows before truncation.
    localparam int PW = H + 32 + CW;
    localparam logic [CW-1:0] LAST_R = CW'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // F(x,k) = rotl(x^k, 3) ^ (x + k), all H bits wide.
    function automatic logic [H-1:0] round_f(input logic [H-1:0] x,
                                             input logic [H-1:0] k);
        logic [H-1:0] t;
        t = x ^ k;
        return {t[H-4:0], t[H-1:H-3]} ^ (x + k);
    endfunction

    // Even rounds use the low key half, odd rounds the high half.
    function automatic logic [H-1:0] subkey(input logic [CW-1:0]      r,
                                            input logic [BLOCK_W-1:0] k);
        logic [H-1:0] khalf;
        khalf = r[0] ? k[BLOCK_W-1:H] : k[H-1:0];
        return khalf ^ H'((PW'(r) + PW'(1)) * PW'(ROUND_CONST));
    endfunction

    function automatic logic [BLOCK_W-1:0] enc_round(input logic [BLOCK_W-1:0] b,
                                                     input logic [H-1:0]       k);
        logic [H-1:0] l;
        logic [H-1:0] r;
        l = b[BLOCK_W-1:H];
        r = b[H-1:0];
        return {r, l ^ round_f(r, k)};
    endfunction

    // Exact inverse of enc_round for the same subkey.
    function automatic logic [BLOCK_W-1:0] dec_round(input logic [BLOCK_W-1:0] b,
                                                     input logic [H-1:0]       k);
        logic [H-1:0] l;
        logic [H-1:0] r;
        l = b[BLOCK_W-1:H];
        r = b[H-1:0];
        return {r ^ round_f(l, k), l};
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      ctr_q, ctr_d;
    logic               mode_q, mode_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] out_q, out_d;
`ifdef FEISTEL_CHAIN_EN
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic [BLOCK_W-1:0] cin_q, cin_d;
`endif

    logic [H-1:0]       sk;
    logic [BLOCK_W-1:0] round_res;
    logic               last_round;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        mode_d  = mode_q;
        key_d   = key_q;
        blk_d   = blk_q;
        out_d   = out_q;
`ifdef FEISTEL_CHAIN_EN
        chain_d = chain_q;
        cin_d   = cin_q;
`endif
        sk         = subkey(ctr_q, key_q);
        round_res  = mode_q ? dec_round(blk_q, sk) : enc_round(blk_q, sk);
        last_round = mode_q ? (ctr_q == '0) : (ctr_q == LAST_R);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    mode_d  = mode;
                    key_d   = key;
                    ctr_d   = mode ? LAST_R : '0;
`ifdef FEISTEL_CHAIN_EN
                    blk_d   = mode ? in_data : (in_data ^ chain_q);
                    cin_d   = in_data;
`else
                    blk_d   = in_data;
`endif
                end
            end
            RUN: begin
                blk_d = round_res;
                if (last_round) begin
                    state_d = DONE;
`ifdef FEISTEL_CHAIN_EN
                    out_d   = mode_q ? (round_res ^ chain_q) : round_res;
`else
                    out_d   = round_res;
`endif
                end else begin
                    // Counter stops on the last round, so it never wraps.
                    ctr_d = mode_q ? (ctr_q - CW'(1)) : (ctr_q + CW'(1));
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef FEISTEL_CHAIN_EN
                    // Chain always carries the ciphertext of the last block.
                    chain_d = mode_q ? cin_q : out_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            out_q   <= '0;
`ifdef FEISTEL_CHAIN_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            out_q   <= out_d;
`ifdef FEISTEL_CHAIN_EN
            chain_q <= chain_d;
`endif
        end
    end

    // Working data registers carry no reset; the FSM qualifies their use.
    always_ff @(posedge clock) begin
        mode_q <= mode_d;
        key_q  <= key_d;
        blk_q  <= blk_d;
`ifdef FEISTEL_CHAIN_EN
        cin_q  <= cin_d;
`endif
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_feistel_round_engine.sv
module tb_feistel_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        mode1, iv1, ir1, ov1, ordy1, busy1;
    logic [15:0] key1, in1, od1;
    logic        mode8, iv8, ir8, ov8, ordy8, busy8;
    logic [15:0] key8, in8, od8;

    int checks = 0;
    int passes = 0;
    logic [15:0] mchain = 16'h0;

    feistel_round_engine #(.BLOCK_W(16), .NUM_ROUNDS(1)) u_one (
        .clock(clk), .reset(rst), .mode(mode1), .key(key1), .in_data(in1),
        .in_valid(iv1), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
        .out_ready(ordy1), .busy(busy1)
    );

    feistel_round_engine u_def (
        .clock(clk), .reset(rst), .mode(mode8), .key(key8), .in_data(in8),
        .in_valid(iv8), .in_ready(ir8), .out_data(od8), .out_valid(ov8),
        .out_ready(ordy8), .busy(busy8)
    );

    // Reference encryption for BLOCK_W=16, NUM_ROUNDS=8.
    function automatic logic [15:0] model_enc(input logic [15:0] k, input logic [15:0] d);
        logic [7:0] l, r, sk, x, f, t;
        l = d[15:8];
        r = d[7:0];
        for (int i = 0; i < 8; i++) begin
            sk = (((i % 2) == 1) ? k[15:8] : k[7:0]) ^ 8'(32'(i + 1) * 32'h9E3779B9);
            x  = r ^ sk;
            f  = {x[4:0], x[7:5]} ^ 8'(r + sk);
            t  = l ^ f;
            l  = r;
            r  = t;
        end
        return {l, r};
    endfunction

    task automatic reset_all();
        rst = 1'b1; iv1 = 1'b0; iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mchain = 16'h0;
    endtask

    task automatic run8(input logic m, input logic [15:0] k, input logic [15:0] d,
                        output logic [15:0] res, output int lat);
        mode8 = m; key8 = k; in8 = d; iv8 = 1'b1; ordy8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = od8;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_all();
        checks++; if (ir8 !== 1'b1) $display("FAIL reset_in_ready got=%0b want=1", ir8); else passes++;
        checks++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", ov8); else passes++;
        checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy8); else passes++;
        checks++; if (od8 !== 16'h0000) $display("FAIL reset_out_data got=%h want=0000", od8); else passes++;
        checks++; if (ir1 !== 1'b1) $display("FAIL reset_in_ready_r1 got=%0b want=1", ir1); else passes++;
        checks++; if (od1 !== 16'h0000) $display("FAIL reset_out_data_r1 got=%h want=0000", od1); else passes++;
    endtask

    task automatic test_one_round();
        ordy1 = 1'b1; mode1 = 1'b0; key1 = 16'h0000; in1 = 16'h1234; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        checks++; if (ov1 !== 1'b0) $display("FAIL r1_enc_cycle1_valid got=%0b want=0", ov1); else passes++;
        checks++; if (busy1 !== 1'b1) $display("FAIL r1_enc_cycle1_busy got=%0b want=1", busy1); else passes++;
        @(posedge clk); #1;
        checks++; if (ov1 !== 1'b1) $display("FAIL r1_enc_cycle2_valid got=%0b want=1", ov1); else passes++;
        checks++; if (od1 !== 16'h3493) $display("FAIL r1_enc_data got=%h want=3493", od1); else passes++;
        @(posedge clk); #1;
        checks++; if (ir1 !== 1'b1) $display("FAIL r1_back_to_idle got=%0b want=1", ir1); else passes++;
        reset_all();
        mode1 = 1'b1; in1 = 16'h3493; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov1 !== 1'b1) $display("FAIL r1_dec_valid got=%0b want=1", ov1); else passes++;
        checks++; if (od1 !== 16'h1234) $display("FAIL r1_dec_data got=%h want=1234", od1); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] pt [10];
        logic [15:0] ct [10];
        logic [15:0] k, exp, res;
        int lat;
        for (int g = 0; g < 20; g++) begin
            reset_all();
            k = 16'($urandom());
            for (int i = 0; i < 10; i++) begin
                pt[i] = 16'($urandom());
                exp = model_enc(k, pt[i] ^ mchain);
`ifdef FEISTEL_CHAIN_EN
                mchain = exp;
`endif
                run8(1'b0, k, pt[i], res, lat);
                ct[i] = res;
                checks++; if (res !== exp) $display("FAIL rand_enc k=%h p=%h got=%h want=%h", k, pt[i], res, exp); else passes++;
                checks++; if (lat !== 8) $display("FAIL rand_enc_latency got=%0d want=8", lat); else passes++;
            end
            reset_all();
            for (int i = 0; i < 10; i++) begin
                run8(1'b1, k, ct[i], res, lat);
                checks++; if (res !== pt[i]) $display("FAIL rand_dec k=%h c=%h got=%h want=%h", k, ct[i], res, pt[i]); else passes++;
                checks++; if (lat !== 8) $display("FAIL rand_dec_latency got=%0d want=8", lat); else passes++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] k, d, k2, d2, exp1, exp2;
        int lat;
        reset_all();
        k = 16'h5A3C; d = 16'hC0DE; k2 = 16'h1357; d2 = 16'h2468;
        exp1 = model_enc(k, d ^ mchain);
`ifdef FEISTEL_CHAIN_EN
        mchain = exp1;
`endif
        ordy8 = 1'b0; mode8 = 1'b0; key8 = k; in8 = d; iv8 = 1'b1;
        @(posedge clk); #1;
        // Scramble key/mode while the block is in flight.
        iv8 = 1'b0; key8 = ~k; mode8 = 1'b1; in8 = 16'hFFFF;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (ov8 !== 1'b1) $display("FAIL bp_valid_timeout got=%0b want=1", ov8); else passes++;
        checks++; if (od8 !== exp1) $display("FAIL bp_first_data got=%h want=%h", od8, exp1); else passes++;
        mode8 = 1'b0; key8 = k2; in8 = d2; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (od8 !== exp1) $display("FAIL bp_hold_data got=%h want=%h", od8, exp1); else passes++;
            checks++; if (ir8 !== 1'b0) $display("FAIL bp_in_ready got=%0b want=0", ir8); else passes++;
            checks++; if (ov8 !== 1'b1) $display("FAIL bp_hold_valid got=%0b want=1", ov8); else passes++;
        end
        ordy8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir8 !== 1'b1) $display("FAIL bp_idle_in_ready got=%0b want=1", ir8); else passes++;
        checks++; if (ov8 !== 1'b0) $display("FAIL bp_idle_out_valid got=%0b want=0", ov8); else passes++;
        exp2 = model_enc(k2, d2 ^ mchain);
`ifdef FEISTEL_CHAIN_EN
        mchain = exp2;
`endif
        @(posedge clk); #1;
        iv8 = 1'b0;
        checks++; if (busy8 !== 1'b1) $display("FAIL bp_second_busy got=%0b want=1", busy8); else passes++;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (od8 !== exp2) $display("FAIL bp_second_data got=%h want=%h", od8, exp2); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] res, exp;
        int lat;
        int seen;
        reset_all();
        ordy8 = 1'b1; mode8 = 1'b0; key8 = 16'hBEEF; in8 = 16'h0F0F; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (busy8 !== 1'b1) $display("FAIL midrun_busy got=%0b want=1", busy8); else passes++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mchain = 16'h0;
        checks++; if (ov8 !== 1'b0) $display("FAIL midrun_out_valid got=%0b want=0", ov8); else passes++;
        checks++; if (ir8 !== 1'b1) $display("FAIL midrun_in_ready got=%0b want=1", ir8); else passes++;
        checks++; if (busy8 !== 1'b0) $display("FAIL midrun_busy_cleared got=%0b want=0", busy8); else passes++;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1) seen = 1;
        end
        checks++; if (seen !== 0) $display("FAIL midrun_aborted_valid got=%0d want=0", seen); else passes++;
        exp = model_enc(16'h1111, 16'h2222 ^ mchain);
`ifdef FEISTEL_CHAIN_EN
        mchain = exp;
`endif
        run8(1'b0, 16'h1111, 16'h2222, res, lat);
        checks++; if (res !== exp) $display("FAIL midrun_fresh_data got=%h want=%h", res, exp); else passes++;
        checks++; if (lat !== 8) $display("FAIL midrun_fresh_latency got=%0d want=8", lat); else passes++;
    endtask

    task automatic test_chain();
        logic [15:0] k, c1, c2, p1, p2;
        int lat;
        reset_all();
        k = 16'h7E57;
        run8(1'b0, k, 16'hABCD, c1, lat);
        run8(1'b0, k, 16'hABCD, c2, lat);
        checks++; if (c1 !== model_enc(k, 16'hABCD)) $display("FAIL chain_c1 got=%h want=%h", c1, model_enc(k, 16'hABCD)); else passes++;
`ifdef FEISTEL_CHAIN_EN
        checks++; if (c1 === c2) $display("FAIL chain_distinct got=%h want=not %h", c2, c1); else passes++;
        checks++; if (c2 !== model_enc(k, 16'hABCD ^ c1)) $display("FAIL chain_c2 got=%h want=%h", c2, model_enc(k, 16'hABCD ^ c1)); else passes++;
`else
        checks++; if (c2 !== model_enc(k, 16'hABCD)) $display("FAIL ecb_c2 got=%h want=%h", c2, model_enc(k, 16'hABCD)); else passes++;
`endif
        reset_all();
        run8(1'b1, k, c1, p1, lat);
        run8(1'b1, k, c2, p2, lat);
        checks++; if (p1 !== 16'hABCD) $display("FAIL chain_p1 got=%h want=abcd", p1); else passes++;
        checks++; if (p2 !== 16'hABCD) $display("FAIL chain_p2 got=%h want=abcd", p2); else passes++;
    endtask

    initial begin
        rst = 1'b0;
        mode1 = 1'b0; key1 = '0; in1 = '0; iv1 = 1'b0; ordy1 = 1'b0;
        mode8 = 1'b0; key8 = '0; in8 = '0; iv8 = 1'b0; ordy8 = 1'b0;
        test_reset();
        test_one_round();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_chain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
